alarm_multi: RTL and testbench
==============================

# alarm_multi

Parametrised successor to the single-alarm top. It keeps a 24-hour BCD time of day from a built-in one-second divider and holds N independently programmable alarm slots, each with its own enable and tone. It runs a ring/snooze/dismiss state machine with automatic ring timeout. Outputs drive the existing sound path: `aud_en` plus a tone select, and the ringing slot index for display.

## Interface
- `N_ALARM`, 4: number of alarm slots, 1..16
- `CLK_PER_SEC`, 100000000: clk cycles per second tick (use 4 in simulation)
- `SNOOZE_SEC`, 300: snooze duration in seconds, ≥1
- `RING_TIMEOUT_SEC`, 60: ring auto-dismiss time in seconds, ≥1
- `TONE_W`, 2: tone select width
- `IDX_W`, derived as max(1, clog2(`N_ALARM`)): slot index width
- `clk` in, 1: system clock
- `rstn` in, 1: asynchronous active-low reset
- `time_load` in, 1: pulse that loads the `*_init` digits
- `hourdec_init`, `hourone_init`, `mindec_init`, `minone_init` in, 4 each: BCD time to load
- `hourdec_now`, `hourone_now`, `mindec_now`, `minone_now` out, 4 each: current time, BCD
- `sec_now` out, 6: seconds, binary 0..59
- `alm_wr` in, 1: pulse that writes slot `alm_idx`
- `alm_idx` in, `IDX_W`: slot to write
- `alm_hourdec`, `alm_hourone`, `alm_mindec`, `alm_minone` in, 4 each: alarm time, BCD
- `alm_on` in, 1: slot enable value to write
- `alm_tone` in, `TONE_W`: slot tone value to write
- `bud_en` in, 1: global alarm enable (level)
- `off_bud` in, 1: dismiss pulse
- `snooze` in, 1: snooze pulse
- `aud_en` out, 1: sound enable
- `aud_tone` out, `TONE_W`: tone of the active slot
- `ring_idx` out, `IDX_W`: active slot
- `bud_state` out, 2: 0 = IDLE, 1 = RING, 2 = SNOOZE

## Operation
- Divider counts 0..`CLK_PER_SEC`-1. `tick` is asserted internally on the terminal count.
- On `tick`, seconds increment. 59 wraps to 0 and carries into minutes.
- Minutes run 00..59 in BCD and carry into hours. Hours run 00..23 in BCD; 23:59:59 wraps to 00:00:00.
- `time_load` with valid BCD (hours ≤ 23, minutes ≤ 59, every digit ≤ 9) sets hh:mm, clears seconds and the divider, and never triggers a match. Invalid loads are ignored.
- `time_load` has priority over a coincident `tick`.
- `alm_wr` with valid BCD time and `alm_idx` < `N_ALARM` writes time, on and tone. Otherwise it is ignored.
- Writing a slot never alters an ongoing ring or snooze.
- Match is evaluated on a `tick` whose next time has seconds = 0. The slot must have on = 1, its hh:mm must equal the next hh:mm, and `bud_en` must be 1. The lowest matching index wins.
- FSM:
  - IDLE → RING on match. Latch `ring_idx` and the tone, and clear the ring timer.
  - RING:
    - `off_bud` → IDLE.
    - Else `snooze` → SNOOZE, loading the snooze counter with `SNOOZE_SEC`.
    - Else, on each `tick`, the ring timer increments. When it reaches `RING_TIMEOUT_SEC` → IDLE.
  - SNOOZE:
    - `off_bud` → IDLE.
    - On each `tick` the counter decrements. On reaching 0 → RING, clearing the ring timer.
    - `snooze` is ignored.
- In RING and SNOOZE, new matches are ignored.
- `bud_en` = 0 forces IDLE on the next edge, from any state.
- `off_bud` and `snooze` in the same cycle: `off_bud` wins.
- `aud_en` = 1 only in RING. `aud_tone` and `ring_idx` hold their last latched values in every state.

## Timing
- Reset (async, `rstn` = 0) takes effect immediately:
  - Time 00:00:00, divider 0.
  - All slots: on = 0, time 00:00, tone 0.
  - FSM IDLE, `aud_en` = 0, `aud_tone` = 0, `ring_idx` = 0, `bud_state` = 0.
- All outputs are registered.
- First `tick` occurs `CLK_PER_SEC` cycles after reset release. Time outputs update on the edge ending the `tick` cycle.
- On a matching minute rollover, `aud_en`/`bud_state` rise on the same edge that the time outputs show mm with seconds 0.
- `off_bud`/`snooze` act on the next edge: 1-cycle latency to `aud_en` fall.
- Timeout: `aud_en` falls on the `tick` edge that completes the `RING_TIMEOUT_SEC`-th second of ringing.
- Snooze expiry: `aud_en` rises on the `tick` edge after `SNOOZE_SEC` ticks in SNOOZE.
- `time_load`/`alm_wr`: written values are visible from the next edge.

## Test plan
Benches use `CLK_PER_SEC` = 4, `SNOOZE_SEC` = 3, `RING_TIMEOUT_SEC` = 5.

- Reset, then 240 ticks → time 00:04:00, `aud_en` stays 0. Load 23:59 and run 60 ticks → 00:00:00.
- Slot 2 = 07:30 (on, tone 3), load 07:29, `bud_en` = 1 → at rollover to 07:30:00, `aud_en` = 1, `ring_idx` = 2, `aud_tone` = 3. `off_bud` → `aud_en` = 0 on the next edge.
- Slots 1 and 3 both at 07:30 → `ring_idx` = 1. `bud_en` = 0 at the same minute → no ring.
- Ringing, then `snooze` → `bud_state` = 2, `aud_en` = 0. After 3 ticks → RING again. Leave untouched → IDLE after 5 ticks.
- `off_bud` and `snooze` in the same cycle while ringing → IDLE. `off_bud` during SNOOZE → IDLE, with no re-ring.
- Invalid load 24:00 and `alm_wr` with minutes 6A are ignored. `time_load` of 07:30 does not trigger a ring. Reset asserted mid-RING → all outputs return to their reset values at once.

Source files
------------

// File: rtl/alarm_multi.sv
// Alarm clock: BCD time of day from a 1 s divider, N alarm slots, ring/snooze/dismiss FSM.
// All outputs registered, 1-cycle latency from inputs; no backpressure (pulse inputs act on the next edge).
module alarm_multi #(
    parameter int N_ALARM          = 4,
    parameter int CLK_PER_SEC      = 100000000,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int TONE_W           = 2,
    parameter int IDX_W            = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              time_load,
    input  logic [3:0]        hourdec_init,
    input  logic [3:0]        hourone_init,
    input  logic [3:0]        mindec_init,
    input  logic [3:0]        minone_init,
    output logic [3:0]        hourdec_now,
    output logic [3:0]        hourone_now,
    output logic [3:0]        mindec_now,
    output logic [3:0]        minone_now,
    output logic [5:0]        sec_now,
    input  logic              alm_wr,
    input  logic [IDX_W-1:0]  alm_idx,
    input  logic [3:0]        alm_hourdec,
    input  logic [3:0]        alm_hourone,
    input  logic [3:0]        alm_mindec,
    input  logic [3:0]        alm_minone,
    input  logic              alm_on,
    input  logic [TONE_W-1:0] alm_tone,
    input  logic              bud_en,
    input  logic              off_bud,
    input  logic              snooze,
    output logic              aud_en,
    output logic [TONE_W-1:0] aud_tone,
    output logic [IDX_W-1:0]  ring_idx,
    output logic [1:0]        bud_state
);

    localparam int DIV_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int RT_W  = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SN_W  = $clog2(SNOOZE_SEC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SEC - 1);
    localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(RING_TIMEOUT_SEC);
    localparam logic [SN_W-1:0]  SN_INIT  = SN_W'(SNOOZE_SEC);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_e;

    function automatic logic bcd_ok(input logic [3:0] hd, input logic [3:0] ho,
                                    input logic [3:0] md, input logic [3:0] mo);
        return ((hd < 4'd2 && ho <= 4'd9) || (hd == 4'd2 && ho <= 4'd3))
               && md <= 4'd5 && mo <= 4'd9;
    endfunction

    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        sec_q, sec_d, nx_sec;
    logic [3:0]        hd_q, ho_q, md_q, mo_q, hd_d, ho_d, md_d, mo_d;
    logic [3:0]        nx_hd, nx_ho, nx_md, nx_mo;
    logic              tick, load_ok, wr_ok;

    logic [15:0]       slot_tm_q   [N_ALARM];
    logic [TONE_W-1:0] slot_tone_q [N_ALARM];
    logic [N_ALARM-1:0] slot_on_q;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [TONE_W-1:0] hit_tone;

    state_e            state_q, state_d;
    logic [RT_W-1:0]   rtmr_q, rtmr_d;
    logic [SN_W-1:0]   snz_q, snz_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              aud_en_q;

    assign tick    = (div_q == DIV_LAST);
    assign load_ok = time_load && bcd_ok(hourdec_init, hourone_init, mindec_init, minone_init);
    assign wr_ok   = alm_wr && bcd_ok(alm_hourdec, alm_hourone, alm_mindec, alm_minone)
                     && (32'(alm_idx) < N_ALARM);

    // Time one tick ahead; also the reference for alarm matching.
    always_comb begin
        nx_sec = sec_q;
        nx_mo  = mo_q;
        nx_md  = md_q;
        nx_ho  = ho_q;
        nx_hd  = hd_q;
        if (tick) begin
            if (sec_q != 6'd59) begin
                nx_sec = sec_q + 6'd1;
            end else begin
                nx_sec = 6'd0;
                if (mo_q != 4'd9) begin
                    nx_mo = mo_q + 4'd1;
                end else begin
                    nx_mo = 4'd0;
                    if (md_q != 4'd5) begin
                        nx_md = md_q + 4'd1;
                    end else begin
                        nx_md = 4'd0;
                        if (hd_q == 4'd2 && ho_q == 4'd3) begin
                            nx_hd = 4'd0;
                            nx_ho = 4'd0;
                        end else if (ho_q == 4'd9) begin
                            nx_ho = 4'd0;
                            nx_hd = hd_q + 4'd1;
                        end else begin
                            nx_ho = ho_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        div_d = (load_ok || tick) ? '0 : div_q + DIV_W'(1);
        sec_d = load_ok ? 6'd0 : nx_sec;
        hd_d  = load_ok ? hourdec_init : nx_hd;
        ho_d  = load_ok ? hourone_init : nx_ho;
        md_d  = load_ok ? mindec_init  : nx_md;
        mo_d  = load_ok ? minone_init  : nx_mo;
    end

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_tone = '0;
        if (tick && !load_ok && nx_sec == 6'd0 && bud_en) begin
            for (int i = N_ALARM - 1; i >= 0; i--) begin
                if (slot_on_q[i] && slot_tm_q[i] == {nx_hd, nx_ho, nx_md, nx_mo}) begin
                    hit      = 1'b1;
                    hit_idx  = IDX_W'(i);
                    hit_tone = slot_tone_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rtmr_d  = rtmr_q;
        snz_d   = snz_q;
        idx_d   = idx_q;
        tone_d  = tone_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_RING;
                    idx_d   = hit_idx;
                    tone_d  = hit_tone;
                    rtmr_d  = '0;
                end
            end
            ST_RING: begin
                if (off_bud) begin
                    state_d = ST_IDLE;
                end else if (snooze) begin
                    state_d = ST_SNOOZE;
                    snz_d   = SN_INIT;
                end else if (tick) begin
                    rtmr_d = rtmr_q + RT_W'(1);
                    if (rtmr_d == RT_LAST) state_d = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (off_bud) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    snz_d = snz_q - SN_W'(1);
                    if (snz_d == '0) begin
                        state_d = ST_RING;
                        rtmr_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bud_en) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q    <= '0;
            sec_q    <= '0;
            hd_q     <= '0;
            ho_q     <= '0;
            md_q     <= '0;
            mo_q     <= '0;
            state_q  <= ST_IDLE;
            rtmr_q   <= '0;
            snz_q    <= '0;
            idx_q    <= '0;
            tone_q   <= '0;
            aud_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            sec_q    <= sec_d;
            hd_q     <= hd_d;
            ho_q     <= ho_d;
            md_q     <= md_d;
            mo_q     <= mo_d;
            state_q  <= state_d;
            rtmr_q   <= rtmr_d;
            snz_q    <= snz_d;
            idx_q    <= idx_d;
            tone_q   <= tone_d;
            aud_en_q <= (state_d == ST_RING);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_on_q <= '0;
            for (int i = 0; i < N_ALARM; i++) begin
                slot_tm_q[i]   <= '0;
                slot_tone_q[i] <= '0;
            end
        end else if (wr_ok) begin
            slot_on_q[alm_idx]   <= alm_on;
            slot_tm_q[alm_idx]   <= {alm_hourdec, alm_hourone, alm_mindec, alm_minone};
            slot_tone_q[alm_idx] <= alm_tone;
        end
    end

    assign hourdec_now = hd_q;
    assign hourone_now = ho_q;
    assign mindec_now  = md_q;
    assign minone_now  = mo_q;
    assign sec_now     = sec_q;
    assign aud_en      = aud_en_q;
    assign aud_tone    = tone_q;
    assign ring_idx    = idx_q;
    assign bud_state   = state_q;

endmodule

// File: tb/tb_alarm_multi.sv
// Directed bench for alarm_multi (4 clk per second, snooze 3 s, ring timeout 5 s).
module tb_alarm_multi;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       time_load = 1'b0;
    logic [3:0] hourdec_init = '0, hourone_init = '0, mindec_init = '0, minone_init = '0;
    logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
    logic [5:0] sec_now;
    logic       alm_wr = 1'b0;
    logic [1:0] alm_idx = '0;
    logic [3:0] alm_hourdec = '0, alm_hourone = '0, alm_mindec = '0, alm_minone = '0;
    logic       alm_on = 1'b0;
    logic [1:0] alm_tone = '0;
    logic       bud_en = 1'b0;
    logic       off_bud = 1'b0;
    logic       snooze = 1'b0;
    logic       aud_en;
    logic [1:0] aud_tone;
    logic [1:0] ring_idx;
    logic [1:0] bud_state;

    int total = 0;
    int bad   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    alarm_multi #(
        .N_ALARM(4), .CLK_PER_SEC(4), .SNOOZE_SEC(3), .RING_TIMEOUT_SEC(5), .TONE_W(2)
    ) dut (
        .clk(clk), .rstn(rstn), .time_load(time_load),
        .hourdec_init(hourdec_init), .hourone_init(hourone_init),
        .mindec_init(mindec_init), .minone_init(minone_init),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now), .sec_now(sec_now),
        .alm_wr(alm_wr), .alm_idx(alm_idx),
        .alm_hourdec(alm_hourdec), .alm_hourone(alm_hourone),
        .alm_mindec(alm_mindec), .alm_minone(alm_minone),
        .alm_on(alm_on), .alm_tone(alm_tone),
        .bud_en(bud_en), .off_bud(off_bud), .snooze(snooze),
        .aud_en(aud_en), .aud_tone(aud_tone), .ring_idx(ring_idx), .bud_state(bud_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st_word(input logic a, input logic [1:0] s,
                                            input logic [1:0] t, input logic [1:0] i);
        return {25'd0, a, s, t, i};
    endfunction

    task automatic exp_time(input string tag, input logic [15:0] hhmm, input logic [5:0] s);
        tag_q.push_back(tag);
        val_q.push_back({8'd0, hhmm, 2'b00, s});
    endtask

    task automatic exp_st(input string tag, input logic a, input logic [1:0] s,
                          input logic [1:0] t, input logic [1:0] i);
        tag_q.push_back(tag);
        val_q.push_back(st_word(a, s, t, i));
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic chk_time();
        chk({8'd0, hourdec_now, hourone_now, mindec_now, minone_now, 2'b00, sec_now});
    endtask

    task automatic chk_st();
        chk(st_word(aud_en, bud_state, aud_tone, ring_idx));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_time(input logic [15:0] hhmm);
        {hourdec_init, hourone_init, mindec_init, minone_init} = hhmm;
        time_load = 1'b1;
        cyc(1);
        time_load = 1'b0;
    endtask

    task automatic wr_slot(input logic [1:0] idx, input logic [15:0] hhmm,
                           input logic on, input logic [1:0] tone);
        alm_idx = idx;
        {alm_hourdec, alm_hourone, alm_mindec, alm_minone} = hhmm;
        alm_on   = on;
        alm_tone = tone;
        alm_wr   = 1'b1;
        cyc(1);
        alm_wr   = 1'b0;
    endtask

    task automatic pulse(input logic o, input logic s);
        off_bud = o;
        snooze  = s;
        cyc(1);
        off_bud = 1'b0;
        snooze  = 1'b0;
    endtask

    initial begin
        // Reset acts asynchronously, before any clock edge.
        #2 rstn = 1'b0;
        #1;
        exp_time("reset_time", 16'h0000, 6'd0);    chk_time();
        exp_st("reset_status", 1'b0, 2'd0, 2'd0, 2'd0); chk_st();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Free run for 240 seconds with alarms off.
        exp_time("run_240s", 16'h0004, 6'd0);
        exp_st("run_240s_quiet", 1'b0, 2'd0, 2'd0, 2'd0);
        cyc(960);
        chk_time(); chk_st();

        // Midnight wrap.
        load_time(16'h2359);
        exp_time("pre_midnight", 16'h2359, 6'd59);
        cyc(236); chk_time();
        exp_time("midnight_wrap", 16'h0000, 6'd0);
        cyc(4); chk_time();

        // Single slot ring, edge alignment and dismiss.
        wr_slot(2'd2, 16'h0730, 1'b1, 2'd3);
        bud_en = 1'b1;
        load_time(16'h0729);
        exp_time("before_match_time", 16'h0729, 6'd59);
        exp_st("before_match_quiet", 1'b0, 2'd0, 2'd0, 2'd0);
        cyc(239); chk_time(); chk_st();
        exp_time("match_time", 16'h0730, 6'd0);
        exp_st("match_ring_slot2", 1'b1, 2'd1, 2'd3, 2'd2);
        cyc(1); chk_time(); chk_st();
        exp_st("dismiss", 1'b0, 2'd0, 2'd3, 2'd2);
        pulse(1'b1, 1'b0); chk_st();

        // Lowest index wins; global enable low blocks the match.
        wr_slot(2'd1, 16'h0730, 1'b1, 2'd1);
        wr_slot(2'd3, 16'h0730, 1'b1, 2'd2);
        load_time(16'h0729);
        exp_st("priority_slot1", 1'b1, 2'd1, 2'd1, 2'd1);
        cyc(240); chk_st();
        pulse(1'b1, 1'b0);
        bud_en = 1'b0;
        load_time(16'h0729);
        exp_st("bud_en_low_no_ring", 1'b0, 2'd0, 2'd1, 2'd1);
        cyc(240); chk_st();
        bud_en = 1'b1;

        // Snooze, re-ring after 3 ticks, then timeout after 5 ticks.
        load_time(16'h0729);
        cyc(240);
        exp_st("ring_after_2s", 1'b1, 2'd1, 2'd1, 2'd1);
        cyc(8); chk_st();
        exp_st("snooze_entered", 1'b0, 2'd2, 2'd1, 2'd1);
        pulse(1'b0, 1'b1); chk_st();
        exp_st("snooze_before_expiry", 1'b0, 2'd2, 2'd1, 2'd1);
        cyc(10); chk_st();
        exp_st("snooze_expiry_ring", 1'b1, 2'd1, 2'd1, 2'd1);
        cyc(1); chk_st();
        exp_st("ring_before_timeout", 1'b1, 2'd1, 2'd1, 2'd1);
        cyc(19); chk_st();
        exp_st("ring_timeout_idle", 1'b0, 2'd0, 2'd1, 2'd1);
        exp_time("timeout_time", 16'h0730, 6'd10);
        cyc(1); chk_st(); chk_time();

        // off_bud beats snooze; off_bud during snooze stays idle.
        load_time(16'h0729);
        cyc(240);
        exp_st("off_and_snooze", 1'b0, 2'd0, 2'd1, 2'd1);
        pulse(1'b1, 1'b1); chk_st();
        load_time(16'h0729);
        cyc(240);
        pulse(1'b0, 1'b1);
        exp_st("off_in_snooze", 1'b0, 2'd0, 2'd1, 2'd1);
        pulse(1'b1, 1'b0); chk_st();
        exp_st("no_rering", 1'b0, 2'd0, 2'd1, 2'd1);
        cyc(20); chk_st();

        // Dropping bud_en while ringing forces idle on the next edge.
        load_time(16'h0729);
        cyc(240);
        bud_en = 1'b0;
        exp_st("bud_en_drop_idle", 1'b0, 2'd0, 2'd1, 2'd1);
        cyc(1); chk_st();
        bud_en = 1'b1;

        // Invalid time load and invalid slot write are ignored.
        wr_slot(2'd0, 16'h1001, 1'b1, 2'd2);
        wr_slot(2'd0, 16'h106A, 1'b0, 2'd0);
        load_time(16'h1000);
        load_time(16'h2400);
        exp_time("invalid_load_ignored", 16'h1000, 6'd0);
        chk_time();
        exp_time("slot0_pre", 16'h1000, 6'd59);
        cyc(238); chk_time();
        exp_st("slot0_ring_after_bad_wr", 1'b1, 2'd1, 2'd2, 2'd0);
        cyc(1); chk_st();
        wr_slot(2'd0, 16'h1001, 1'b0, 2'd1);
        exp_st("write_keeps_ring", 1'b1, 2'd1, 2'd2, 2'd0);
        chk_st();
        pulse(1'b1, 1'b0);
        load_time(16'h0730);
        exp_st("load_no_trigger", 1'b0, 2'd0, 2'd2, 2'd0);
        cyc(8); chk_st();

        // Reset mid-ring clears everything immediately.
        load_time(16'h0729);
        exp_st("ring_before_reset", 1'b1, 2'd1, 2'd1, 2'd1);
        cyc(240); chk_st();
        #2 rstn = 1'b0;
        #1;
        exp_st("reset_mid_ring", 1'b0, 2'd0, 2'd0, 2'd0);
        exp_time("reset_mid_ring_time", 16'h0000, 6'd0);
        chk_st(); chk_time();
        cyc(2);
        rstn = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
